// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply and
// restoring divide, one step per cycle, holding the pipeline with stall_o until done_o.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      ALUOp_i,
    input  logic [9:0]      funct_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_q, state_d;
    logic [5:0]          cnt_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     b_q;
    logic [XLEN-1:0]     res_q;
    logic [2:0]          op_q;
    logic                neg_q;

    // Two's-complement negate when the sign flag is set.
    function automatic logic [2*XLEN-1:0] cond_neg(input logic [2*XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    // Magnitude of an operand that may be interpreted as signed.
    function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v < 0) ? XLEN'(-v) : XLEN'(v);
    endfunction

    // Request decode and operand preparation for the accepting cycle
    logic                   req, is_div, a_signed, b_signed, a_neg, b_neg, neg_d;
    logic                   div_zero, div_ovf, special;
    logic [2:0]             op;
    logic signed [XLEN-1:0] rs1_s, rs2_s;
    logic [XLEN-1:0]        a_mag, b_mag, spec_res;

    assign rs1_s    = rs1_i;
    assign rs2_s    = rs2_i;
    assign op       = funct_i[2:0];
    assign req      = start_i && (ALUOp_i == 2'b10) && (funct_i[9:3] == 7'b0000001);
    assign is_div   = op[2];
    assign a_signed = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign b_signed = op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    assign a_neg    = a_signed && (rs1_s < 0);
    assign b_neg    = b_signed && (rs2_s < 0);
    // Remainder follows the dividend's sign; product and quotient follow the XOR.
    assign neg_d    = (is_div && op[1]) ? a_neg : (a_neg ^ b_neg);
    assign a_mag    = magnitude(rs1_s, a_signed);
    assign b_mag    = magnitude(rs2_s, b_signed);
    assign div_zero = is_div && (rs2_i == '0);
    assign div_ovf  = (op == OP_DIV || op == OP_REM) && (rs1_i == INT_MIN) && (rs2_i == '1);
    assign special  = div_zero || div_ovf;
    assign spec_res = div_zero ? (op[1] ? rs1_i : '1) : (op[1] ? '0 : INT_MIN);

    // One radix-2 step: shift-add multiply or restoring shift-subtract divide
    logic [XLEN:0]       mul_sum, div_trial;
    logic                div_ok;
    logic [2*XLEN-1:0]   mul_next, div_next, acc_step;
    logic [2*XLEN-1:0]   mul_full, quo_full, rem_full;
    logic [XLEN-1:0]     res_fin;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    assign div_ok    = !div_trial[XLEN];
    assign div_next  = {(div_ok ? div_trial[XLEN-1:0] : acc_q[2*XLEN-2:XLEN-1]),
                        acc_q[XLEN-2:0], div_ok};
    assign acc_step  = op_q[2] ? div_next : mul_next;

    assign mul_full  = cond_neg(mul_next, neg_q);
    assign quo_full  = cond_neg({{XLEN{1'b0}}, div_next[XLEN-1:0]}, neg_q);
    assign rem_full  = cond_neg({{XLEN{1'b0}}, div_next[2*XLEN-1:XLEN]}, neg_q);

    always_comb begin
        res_fin = '0;
        if (op_q[2])
            res_fin = op_q[1] ? rem_full[XLEN-1:0] : quo_full[XLEN-1:0];
        else
            res_fin = (op_q == OP_MUL) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    end

    // Control FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        stall_o  = 1'b0;
        done_o   = 1'b0;
        result_o = '0;
        if (start_i) begin
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        stall_o = 1'b1;
                        state_d = special ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    stall_o = 1'b1;
                    if (cnt_q == 6'(XLEN-1)) state_d = DONE;
                end
                DONE: begin
                    done_o   = 1'b1;
                    result_o = res_q;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath registers; frozen whenever start_i is low
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            acc_q <= '0;
            b_q   <= '0;
            res_q <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
        end else if (start_i) begin
            if (state_q == IDLE && req) begin
                op_q  <= op;
                neg_q <= neg_d;
                cnt_q <= '0;
                acc_q <= {{XLEN{1'b0}}, a_mag};
                b_q   <= b_mag;
                if (special) res_q <= spec_res;
            end else if (state_q == BUSY) begin
                acc_q <= acc_step;
                cnt_q <= cnt_q + 6'd1;
                if (cnt_q == 6'(XLEN-1)) res_q <= res_fin;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: driver queues expected result and stall length,
// monitor checks each done_o pulse against the queue head.
module tb_ex_muldiv;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i;
    logic [1:0]  ALUOp_i;
    logic [9:0]  funct_i;
    logic [31:0] rs1_i, rs2_i;
    logic        stall_o, done_o;
    logic [31:0] result_o;

    ex_muldiv #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ALUOp_i(ALUOp_i),
        .funct_i(funct_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .stall_o(stall_o), .done_o(done_o), .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    always @(posedge clk_i) cyc++;

    typedef struct {
        logic [31:0] res;
        int          stalls;
        string       name;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference model straight from the RV32M definitions.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        longint      sa, sb, r;
        ea = (op != 3'b011) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op <= 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'b000: return p[31:0];
            3'b001, 3'b010, 3'b011: return p[63:32];
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                r = sa / sb; return r[31:0];
            end
            3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                r = sa % sb; return r[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return !op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: counts stall cycles and checks every done_o pulse against the queue head
    int   stall_cnt = 0;
    exp_t cur;
    always @(negedge clk_i) begin
        if (rst_i) begin
            stall_cnt = 0;
        end else begin
            if (stall_o) stall_cnt++;
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk({cur.name, "_result"}, result_o, cur.res);
                    chk({cur.name, "_stall_cycles"}, 32'(stall_cnt), 32'(cur.stalls));
                end
                stall_cnt = 0;
            end
        end
    end

    // Issue one M-op at #1 after an edge; return the cycle in which done_o was seen.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input string name, input bit scramble,
                         input int freeze_at, output int done_cyc);
        int n;
        ALUOp_i = 2'b10;
        funct_i = {7'b0000001, op};
        rs1_i   = a;
        rs2_i   = b;
        exp_q.push_back('{expv, is_special(op, a, b) ? 1 : 33, name});
        n = 0;
        do begin
            @(posedge clk_i); #1;
            n++;
            if (scramble) begin
                rs1_i = $urandom;
                rs2_i = $urandom;
            end
            if (n == freeze_at) begin
                start_i = 1'b0;
                #1 chk({name, "_freeze_stall"}, {31'b0, stall_o}, 32'd0);
                repeat (5) @(posedge clk_i);
                #1 start_i = 1'b1;
            end
        end while (!done_o && n < 200);
        chk({name, "_done_seen"}, {31'b0, done_o}, 32'd1);
        done_cyc = cyc;
        @(posedge clk_i); #1;
    endtask

    int d1, d2, dx;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    initial begin
        rst_i = 1'b1; start_i = 1'b1; ALUOp_i = 2'b00; funct_i = '0; rs1_i = '0; rs2_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_stall", {31'b0, stall_o}, 32'd0);
        chk("reset_done", {31'b0, done_o}, 32'd0);
        chk("reset_result", result_o, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        issue(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7_m3", 1'b1, 0, dx);
        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1", 1'b0, 0, dx);
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max", 1'b0, 0, dx);
        issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1", 1'b0, 0, dx);
        issue(3'b100, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFD, "div_m20_6", 1'b1, 0, dx);
        issue(3'b110, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFE, "rem_m20_6", 1'b0, 0, dx);
        issue(3'b101, 32'd20, 32'd6, 32'd3, "divu_20_6", 1'b0, 0, dx);
        issue(3'b100, 32'd1234, 32'd0, 32'hFFFFFFFF, "div_by_zero", 1'b0, 0, dx);
        issue(3'b111, 32'hCAFEF00D, 32'd0, 32'hCAFEF00D, "remu_by_zero", 1'b0, 0, dx);
        issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_overflow", 1'b0, 0, dx);
        issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_overflow", 1'b0, 0, dx);

        // Back-to-back multiplies followed by a non-M instruction
        issue(3'b000, 32'd1000, 32'd3000, 32'd3000000, "b2b_mul1", 1'b0, 0, d1);
        issue(3'b000, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFB, "b2b_mul2", 1'b0, 0, d2);
        chk("b2b_done_spacing", 32'(d2 - d1), 32'd34);
        ALUOp_i = 2'b10; funct_i = 10'b0000000_000; rs1_i = 32'd1; rs2_i = 32'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("add_stall", {31'b0, stall_o}, 32'd0);
            chk("add_done", {31'b0, done_o}, 32'd0);
            @(posedge clk_i); #1;
        end

        // Reset during BUSY cycle 10
        ALUOp_i = 2'b10; funct_i = {7'b0000001, 3'b000}; rs1_i = 32'd5; rs2_i = 32'd9;
        repeat (11) @(posedge clk_i);
        #1;
        chk("busy_stall_before_reset", {31'b0, stall_o}, 32'd1);
        rst_i = 1'b1; ALUOp_i = 2'b00;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("after_reset_stall", {31'b0, stall_o}, 32'd0);
        chk("after_reset_done", {31'b0, done_o}, 32'd0);
        chk("after_reset_result", result_o, 32'd0);
        issue(3'b101, 32'd100, 32'd7, 32'd14, "divu_100_7", 1'b0, 0, dx);

        // start_i held low for 5 cycles in the middle of an operation
        issue(3'b011, 32'h12345678, 32'h9ABCDEF0, model(3'b011, 32'h12345678, 32'h9ABCDEF0),
              "mulhu_freeze", 1'b1, 10, dx);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = rnd_operand();
            rb  = rnd_operand();
            issue(rop, ra, rb, model(rop, ra, rb), $sformatf("rand%0d_op%0d", i, rop),
                  1'($urandom_range(0, 1)), 0, dx);
        end

        ALUOp_i = 2'b00; funct_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
